// File: rtl/wb_return_queue.sv
// wb_return_queue: two-lane writeback return buffer between the execution
// pipes (A, B) and the register file write ports. Each lane is a FIFO that
// drains at most one entry per cycle. Same-address heads are serialised: A
// goes first and B is owed the next slot.
// Optional feature macro: WB_RETURN_BYPASS_EN. When it is defined, a result
// pushed into an empty, unheld lane goes straight to that lane's outputs.
module wb_return_queue #(
    parameter int NUM_QUEUE_ENTRIES = 8,
    parameter int STALL_MARGIN      = 2,
    parameter int CW                = $clog2(NUM_QUEUE_ENTRIES) + 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          flushBack_i,
    input  logic          resValidA_i,
    input  logic [4:0]    resAddrA_i,
    input  logic [15:0]   resValA_i,
    input  logic [1:0]    resStatusA_i,
    input  logic          resValidB_i,
    input  logic [4:0]    resAddrB_i,
    input  logic [15:0]   resValB_i,
    input  logic [1:0]    resStatusB_i,
    output logic          shouldAStall_o,
    output logic          shouldBStall_o,
    output logic          wbA_o,
    output logic [4:0]    wbAddrA_o,
    output logic [15:0]   wbValA_o,
    output logic [1:0]    operationStatusA_o,
    output logic          wbB_o,
    output logic [4:0]    wbAddrB_o,
    output logic [15:0]   wbValB_o,
    output logic [1:0]    operationStatusB_o,
    output logic [CW-1:0] countA_o,
    output logic [CW-1:0] countB_o,
    output logic [1:0]    overflow_o
);

    localparam int PW = $clog2(NUM_QUEUE_ENTRIES);
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(NUM_QUEUE_ENTRIES);
    localparam logic [CW-1:0] STALL_LEVEL = CW'(NUM_QUEUE_ENTRIES - STALL_MARGIN);

    typedef enum logic {
        ARB_A_FIRST = 1'b0,
        ARB_B_OWED  = 1'b1
    } arb_state_t;

    // Lane index 0 is pipe A, lane index 1 is pipe B.
    logic          pushVld  [2];
    logic [4:0]    pushAddr [2];
    logic [15:0]   pushVal  [2];
    logic [1:0]    pushStat [2];

    logic [4:0]    addrMem_q [2][NUM_QUEUE_ENTRIES];
    logic [15:0]   valMem_q  [2][NUM_QUEUE_ENTRIES];
    logic [1:0]    statMem_q [2][NUM_QUEUE_ENTRIES];

    logic [PW-1:0] headPtr_q [2];
    logic [PW-1:0] headPtr_d [2];
    logic [PW-1:0] tailPtr_q [2];
    logic [PW-1:0] tailPtr_d [2];
    logic [CW-1:0] count_q   [2];
    logic [CW-1:0] count_d   [2];
    logic          stall_q   [2];
    logic          stall_d   [2];
    logic          wb_q      [2];
    logic          wb_d      [2];
    logic [4:0]    wbAddr_q  [2];
    logic [4:0]    wbAddr_d  [2];
    logic [15:0]   wbVal_q   [2];
    logic [15:0]   wbVal_d   [2];
    logic [1:0]    wbStat_q  [2];
    logic [1:0]    wbStat_d  [2];
    logic [1:0]    overflow_q;
    logic [1:0]    overflow_d;
    arb_state_t    arb_q;
    arb_state_t    arb_d;

    logic          headReady [2];
    logic [4:0]    headAddr  [2];
    logic          pop       [2];
    logic          bypass    [2];
    logic          accept    [2];
    logic          drop      [2];
    logic          collision;

    assign pushVld[0]  = resValidA_i;
    assign pushAddr[0] = resAddrA_i;
    assign pushVal[0]  = resValA_i;
    assign pushStat[0] = resStatusA_i;
    assign pushVld[1]  = resValidB_i;
    assign pushAddr[1] = resAddrB_i;
    assign pushVal[1]  = resValB_i;
    assign pushStat[1] = resStatusB_i;

    // Head-of-lane view: whether a lane has something to drain and where it goes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            headReady[i] = (count_q[i] != '0);
            headAddr[i]  = addrMem_q[i][headPtr_q[i]];
        end
    end

    // Collision arbitration: A wins a fresh clash, B is owed the very next slot.
    always_comb begin
        collision = headReady[0] && headReady[1] && (headAddr[0] == headAddr[1]);
        pop[0]    = headReady[0] && !(collision && (arb_q == ARB_B_OWED));
        pop[1]    = headReady[1] && !(collision && (arb_q == ARB_A_FIRST));
        arb_d     = arb_q;
        if (flushBack_i) begin
            arb_d = ARB_A_FIRST;
        end else if (collision && (arb_q == ARB_A_FIRST)) begin
            arb_d = ARB_B_OWED;
        end else if (pop[1]) begin
            arb_d = ARB_A_FIRST;
        end
    end

    // Bypass selection; never lets a bypassed write clash with the other lane's write.
    always_comb begin
        bypass[0] = 1'b0;
        bypass[1] = 1'b0;
`ifdef WB_RETURN_BYPASS_EN
        bypass[0] = pushVld[0] && (count_q[0] == '0)
                    && !(pop[1] && (headAddr[1] == pushAddr[0]));
        bypass[1] = pushVld[1] && (count_q[1] == '0) && (arb_q == ARB_A_FIRST)
                    && !(pop[0] && (headAddr[0] == pushAddr[1]))
                    && !(bypass[0] && (pushAddr[0] == pushAddr[1]));
`endif
    end

    // Per-lane next state: pointers, occupancy, drop flags and the registered write port.
    always_comb begin
        overflow_d = overflow_q;
        for (int i = 0; i < 2; i++) begin
            accept[i]    = pushVld[i] && !bypass[i] && ((count_q[i] != FULL_LEVEL) || pop[i]);
            drop[i]      = pushVld[i] && !bypass[i] && (count_q[i] == FULL_LEVEL) && !pop[i];
            headPtr_d[i] = headPtr_q[i];
            tailPtr_d[i] = tailPtr_q[i];
            count_d[i]   = count_q[i];
            wb_d[i]      = 1'b0;
            wbAddr_d[i]  = wbAddr_q[i];
            wbVal_d[i]   = wbVal_q[i];
            wbStat_d[i]  = wbStat_q[i];
            if (flushBack_i) begin
                headPtr_d[i] = '0;
                tailPtr_d[i] = '0;
                count_d[i]   = '0;
            end else begin
                if (pop[i]) begin
                    headPtr_d[i] = headPtr_q[i] + PW'(1);
                end
                if (accept[i]) begin
                    tailPtr_d[i] = tailPtr_q[i] + PW'(1);
                end
                count_d[i] = count_q[i] + CW'(accept[i]) - CW'(pop[i]);
                if (drop[i]) begin
                    overflow_d[1-i] = 1'b1;
                end
                if (bypass[i]) begin
                    wb_d[i]     = 1'b1;
                    wbAddr_d[i] = pushAddr[i];
                    wbVal_d[i]  = pushVal[i];
                    wbStat_d[i] = pushStat[i];
                end else if (pop[i]) begin
                    wb_d[i]     = 1'b1;
                    wbAddr_d[i] = headAddr[i];
                    wbVal_d[i]  = valMem_q[i][headPtr_q[i]];
                    wbStat_d[i] = statMem_q[i][headPtr_q[i]];
                end
            end
            stall_d[i] = (count_d[i] >= STALL_LEVEL);
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock_i) begin
        for (int i = 0; i < 2; i++) begin
            if (accept[i] && !flushBack_i) begin
                addrMem_q[i][tailPtr_q[i]] <= pushAddr[i];
                valMem_q[i][tailPtr_q[i]]  <= pushVal[i];
                statMem_q[i][tailPtr_q[i]] <= pushStat[i];
            end
        end
    end

    // Control and output registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) begin
                headPtr_q[i] <= '0;
                tailPtr_q[i] <= '0;
                count_q[i]   <= '0;
                stall_q[i]   <= 1'b0;
                wb_q[i]      <= 1'b0;
                wbAddr_q[i]  <= '0;
                wbVal_q[i]   <= '0;
                wbStat_q[i]  <= '0;
            end
            overflow_q <= '0;
            arb_q      <= ARB_A_FIRST;
        end else begin
            for (int i = 0; i < 2; i++) begin
                headPtr_q[i] <= headPtr_d[i];
                tailPtr_q[i] <= tailPtr_d[i];
                count_q[i]   <= count_d[i];
                stall_q[i]   <= stall_d[i];
                wb_q[i]      <= wb_d[i];
                wbAddr_q[i]  <= wbAddr_d[i];
                wbVal_q[i]   <= wbVal_d[i];
                wbStat_q[i]  <= wbStat_d[i];
            end
            overflow_q <= overflow_d;
            arb_q      <= arb_d;
        end
    end

    assign shouldAStall_o     = stall_q[0];
    assign shouldBStall_o     = stall_q[1];
    assign wbA_o              = wb_q[0];
    assign wbAddrA_o          = wbAddr_q[0];
    assign wbValA_o           = wbVal_q[0];
    assign operationStatusA_o = wbStat_q[0];
    assign wbB_o              = wb_q[1];
    assign wbAddrB_o          = wbAddr_q[1];
    assign wbValB_o           = wbVal_q[1];
    assign operationStatusB_o = wbStat_q[1];
    assign countA_o           = count_q[0];
    assign countB_o           = count_q[1];
    assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_wb_return_queue.sv
// tb_wb_return_queue: drives directed and random traffic into wb_return_queue
// and compares every output each cycle against a queue-based reference model.
module tb_wb_return_queue;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] val;
        logic [1:0]  st;
    } entry_t;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          flushBack;
    logic          resValidA, resValidB;
    logic [4:0]    resAddrA, resAddrB;
    logic [15:0]   resValA, resValB;
    logic [1:0]    resStatA, resStatB;
    logic          stallA, stallB, wbA, wbB;
    logic [4:0]    wbAddrA, wbAddrB;
    logic [15:0]   wbValA, wbValB;
    logic [1:0]    opStatA, opStatB;
    logic [CW-1:0] countA, countB;
    logic [1:0]    overflow;

    int checkCount = 0;
    int errorCount = 0;

    entry_t qA[$];
    entry_t qB[$];
    logic   bOwed;
    logic   expWbA, expWbB;
    entry_t expA, expB;
    logic [1:0] expOvf;

    wb_return_queue #(.NUM_QUEUE_ENTRIES(DEPTH), .STALL_MARGIN(MARGIN)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .flushBack_i(flushBack),
        .resValidA_i(resValidA), .resAddrA_i(resAddrA), .resValA_i(resValA), .resStatusA_i(resStatA),
        .resValidB_i(resValidB), .resAddrB_i(resAddrB), .resValB_i(resValB), .resStatusB_i(resStatB),
        .shouldAStall_o(stallA), .shouldBStall_o(stallB),
        .wbA_o(wbA), .wbAddrA_o(wbAddrA), .wbValA_o(wbValA), .operationStatusA_o(opStatA),
        .wbB_o(wbB), .wbAddrB_o(wbAddrB), .wbValB_o(wbValB), .operationStatusB_o(opStatB),
        .countA_o(countA), .countB_o(countB), .overflow_o(overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock_i = ~clock_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        qA.delete();
        qB.delete();
        bOwed  = 1'b0;
        expWbA = 1'b0;
        expWbB = 1'b0;
        expA   = '0;
        expB   = '0;
        expOvf = 2'b00;
    endtask

    // One rising edge worth of behaviour, taken straight from the queue rules.
    task automatic modelStep();
        logic readyA, readyB, sameAddr, takeA, takeB;
        if (flushBack) begin
            qA.delete();
            qB.delete();
            expWbA = 1'b0;
            expWbB = 1'b0;
            bOwed  = 1'b0;
        end else begin
            readyA   = (qA.size() > 0);
            readyB   = (qB.size() > 0);
            sameAddr = readyA && readyB && (qA[0].addr == qB[0].addr);
            takeA    = readyA && !(sameAddr && bOwed);
            takeB    = readyB && !(sameAddr && !bOwed);
            if (sameAddr && !bOwed) bOwed = 1'b1;
            else if (takeB)         bOwed = 1'b0;
            expWbA = takeA;
            expWbB = takeB;
            if (takeA) expA = qA.pop_front();
            if (takeB) expB = qB.pop_front();
            if (resValidA) begin
                if (qA.size() < DEPTH) qA.push_back('{resAddrA, resValA, resStatA});
                else                   expOvf[1] = 1'b1;
            end
            if (resValidB) begin
                if (qB.size() < DEPTH) qB.push_back('{resAddrB, resValB, resStatB});
                else                   expOvf[0] = 1'b1;
            end
        end
    endtask

    task automatic compareState();
        checkOutput("wbA",     wbA,     expWbA);
        checkOutput("wbAddrA", wbAddrA, expA.addr);
        checkOutput("wbValA",  wbValA,  expA.val);
        checkOutput("opStatA", opStatA, expA.st);
        checkOutput("countA",  countA,  qA.size());
        checkOutput("stallA",  stallA,  qA.size() >= DEPTH - MARGIN);
        checkOutput("wbB",     wbB,     expWbB);
        checkOutput("wbAddrB", wbAddrB, expB.addr);
        checkOutput("wbValB",  wbValB,  expB.val);
        checkOutput("opStatB", opStatB, expB.st);
        checkOutput("countB",  countB,  qB.size());
        checkOutput("stallB",  stallB,  qB.size() >= DEPTH - MARGIN);
        checkOutput("overflow", overflow, expOvf);
    endtask

    // Drive one cycle of inputs at the falling edge, clock it, check at the next falling edge.
    task automatic applyStimulus(input logic vA, input logic [4:0] aA, input logic [15:0] dA, input logic [1:0] sA,
                                 input logic vB, input logic [4:0] aB, input logic [15:0] dB, input logic [1:0] sB,
                                 input logic fl);
        resValidA = vA; resAddrA = aA; resValA = dA; resStatA = sA;
        resValidB = vB; resAddrB = aB; resValB = dB; resStatB = sB;
        flushBack = fl;
        @(posedge clock_i);
        modelStep();
        @(negedge clock_i);
        compareState();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between clock edges; everything must clear before the next edge.
    task automatic applyAsyncReset();
        #2;
        reset_i = 1'b1;
        #1;
        modelReset();
        compareState();
        resValidA = 0; resValidB = 0; flushBack = 0;
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        flushBack = 0;
        resValidA = 0; resAddrA = 0; resValA = 0; resStatA = 0;
        resValidB = 0; resAddrB = 0; resValB = 0; resStatB = 0;
        modelReset();
        repeat (2) @(negedge clock_i);
        compareState();
        reset_i = 1'b0;

        $display("[TB] single push latency");
        applyStimulus(1, 3, 16'h1234, 0, 0, 0, 0, 0, 0);
        checkOutput("latencyEarly", wbA, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("latencyWb", wbA, 1'b1);
        checkOutput("latencyVal", wbValA, 16'h1234);
        idle(2);

        $display("[TB] colliding fill to overflow");
        for (int k = 0; k < 22; k++)
            applyStimulus(1, 5, 16'(16'h1000 + k), 2'(k), 1, 5, 16'(16'h2000 + k), 2'(k + 1), 0);
        checkOutput("fillOverflow", overflow, 2'b11);
        idle(20);

        $display("[TB] same-address pair and A stream");
        applyStimulus(1, 5, 16'hAAAA, 1, 1, 5, 16'hBBBB, 2, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 5, 16'(16'hA000 + k), 0, 0, 0, 0, 0, 0);
        idle(6);

        $display("[TB] different addresses drain together");
        applyStimulus(1, 7, 16'h0707, 3, 1, 9, 16'h0909, 1, 0);
        idle(1);
        checkOutput("pairBoth", {wbA, wbB}, 2'b11);
        idle(2);

        $display("[TB] flush with concurrent push");
        for (int k = 0; k < 8; k++) applyStimulus(1, 2, 16'(k), 0, 1, 2, 16'(k + 100), 0, 0);
        applyStimulus(1, 4, 16'h4444, 0, 1, 6, 16'h6666, 0, 1);
        checkOutput("flushCount", countA, 0);
        idle(3);

        $display("[TB] asynchronous reset mid-drain");
        for (int k = 0; k < 6; k++) applyStimulus(1, 1, 16'(k), 0, 1, 1, 16'(k + 50), 0, 0);
        applyAsyncReset();
        idle(4);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            applyStimulus($urandom_range(0, 99) < 65, 5'($urandom_range(0, 3)), 16'($urandom), 2'($urandom),
                          $urandom_range(0, 99) < 65, 5'($urandom_range(0, 3)), 16'($urandom), 2'($urandom),
                          $urandom_range(0, 99) < 2);
            if ($urandom_range(0, 199) == 0) applyAsyncReset();
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
